aq_rtu_fflags_collect: RTL and testbench
========================================

AQ_RTU_FFLAGS_COLLECT -- requirements
Module: aq_rtu_fflags_collect

Interface
REQ-001 SHALL provide: forever_cpuclk  in  1  sole clock, rising edge.
REQ-002 SHALL provide: cpurst  in  1  reset, asynchronous assert, active-high.
REQ-003 SHALL provide: vfpu_rtu_ex_vld  in  1  FP pipe completion with flags, in program order.
REQ-004 SHALL provide: vfpu_rtu_ex_fflags  in  5  {NV,DZ,OF,UF,NX} flags of the completing instruction.
REQ-005 SHALL provide: rtu_vfpu_ex_rdy  out  1  collector can accept a completion (= not full).
REQ-006 SHALL provide: rtu_retire_fp_vld  in  1  oldest FP instruction retires this cycle.
REQ-007 SHALL provide: rtu_yy_xx_flush  in  1  discard all unretired (buffered) completions.
REQ-008 SHALL provide: cp0_rtu_fflags_wr  in  1  CSR write to fcsr, fflags or fxcr commits this cycle.
REQ-009 SHALL provide: rtu_cp0_fflags_updt  out  1  fflags OR-update strobe to the CP0 float CSR.
REQ-010 SHALL provide: rtu_cp0_fflags  out  5  flags to OR into fflags; valid while updt is high.
REQ-011 SHALL provide: rtu_cp0_fs_dirty  out  1  equals updt AND (flags != 0).
REQ-012 SHALL provide: rtu_retire_err  out  1  sticky flag: a retire arrived while the FIFO was empty.

Function
REQ-013 SHALL hold completions in a 4-entry in-order FIFO, 5 bits per entry.
- Read/write pointers: 2 bits each, plus a wrap bit.
- full = pointers equal with wrap bits differing.
- empty = pointers and wrap bits equal.
REQ-014 SHALL push when vfpu_rtu_ex_vld && rtu_vfpu_ex_rdy; a vld asserted while not ready is ignored, and the FP pipe holds it.
REQ-015 SHALL pop the head entry when rtu_retire_fp_vld && !empty.
REQ-016 SHALL support push and pop in the same cycle, including when full (pop frees, push refills); rdy is still computed from the registered full state.
REQ-017 SHALL ignore a retire while empty, with no pop and no update, and SHALL set rtu_retire_err until reset.
REQ-018 SHALL keep a registered accumulator (acc_vld, acc_flags[4:0]) updated every cycle as follows.
- If a pop occurs and updt is high: acc_flags <= popped flags, acc_vld <= 1.
- If a pop occurs and updt is low: acc_flags <= acc_flags | popped flags, acc_vld <= 1.
- If no pop occurs: acc_vld <= 0.
REQ-019 SHALL drive rtu_cp0_fflags_updt = acc_vld and rtu_cp0_fflags = acc_flags directly from registers. Latency is retire edge -> updt high on the next cycle.
REQ-020 SHALL produce one updt cycle per popped entry. Back-to-back retires give back-to-back updt cycles; zero-flag entries still strobe updt, with fs_dirty low.
REQ-021 SHALL respond to cp0_rtu_fflags_wr by clearing acc_vld and acc_flags next cycle and dropping any same-cycle pop's flags; the FIFO pop itself still occurs. CSR-written fflags supersede older flags.
REQ-022 SHALL respond to rtu_yy_xx_flush by clearing the FIFO (pointers and wrap bits to 0) next cycle and dropping any same-cycle push.
- A same-cycle pop still feeds the accumulator.
- The accumulator is unaffected by flush.
REQ-023 SHALL give cp0_rtu_fflags_wr priority over the pop-to-accumulator path, and flush priority over push.

Reset
REQ-024 SHALL, on cpurst assertion, asynchronously clear the pointers, wrap bits, acc_vld, acc_flags and rtu_retire_err.
REQ-025 SHALL drive these values while reset is asserted: rtu_vfpu_ex_rdy=1, rtu_cp0_fflags_updt=0, rtu_cp0_fflags=5'b0, rtu_cp0_fs_dirty=0, rtu_retire_err=0.
REQ-026 SHALL leave FIFO entry storage non-reset, since it is only read when non-empty.
REQ-027 SHALL lose all in-flight contents on reset mid-operation, with no update strobe generated.

Structure
REQ-028 SHALL place FFLAGS_W=5, FIFO_DEPTH=4 and the flag bit positions (NV=4, DZ=3, OF=2, UF=1, NX=0) in the shared RTU package.
REQ-029 SHALL implement the FIFO as one sub-module, aq_rtu_fflags_fifo (push/pop/flush, full/empty, head data); the accumulator stays in the top.

Verification
REQ-030 SHALL cover reset then single flow: push 5'b00001, retire 2 cycles later -> next cycle updt=1, fflags=5'b00001, fs_dirty=1, held 1 cycle.
REQ-031 SHALL cover fill: 4 pushes with no retire -> rdy=0; a 5th vld held 3 cycles is not accepted; one retire -> rdy=1 next cycle and the 5th push is accepted.
REQ-032 SHALL cover back-to-back retires: entries 5'b10000 and 5'b00100 retire on consecutive cycles -> updt high 2 cycles with fflags 5'b10000 then 5'b00100.
REQ-033 SHALL cover flush with simultaneous pop: FIFO holds 3 entries, flush with retire in the same cycle -> one updt carrying the head flags; FIFO empty, rdy=1.
REQ-034 SHALL cover CSR-write collision: retire 5'b01000 with cp0_rtu_fflags_wr in the same cycle -> no updt next cycle; the FIFO count still decrements.
REQ-035 SHALL cover empty retire: retire with the FIFO empty -> no updt, rtu_retire_err=1 until cpurst, and cpurst mid-stream clears all outputs immediately.

Source files
------------

// File: rtl/aq_rtu_fflags_collect_pkg.sv
// Shared RTU definitions for FP exception-flag collection: widths, FIFO depth and flag bit positions.
package aq_rtu_fflags_collect_pkg;

  localparam int unsigned FFLAGS_W   = 5;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);

  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  typedef logic [FFLAGS_W-1:0] fflags_t;

endpackage

// File: rtl/aq_rtu_fflags_fifo.sv
// In-order FIFO of completed FP instruction flags; pointers carry a wrap bit for full/empty.
module aq_rtu_fflags_fifo
  import aq_rtu_fflags_collect_pkg::*;
(
  input  logic                forever_cpuclk,
  input  logic                cpurst,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [FFLAGS_W-1:0] wdata,
  output logic [FFLAGS_W-1:0] rdata,
  output logic                full,
  output logic                empty
);

  // MSB of each pointer is the wrap bit.
  logic [PTR_W:0] wptr_q, wptr_d;
  logic [PTR_W:0] rptr_q, rptr_d;
  fflags_t        mem_q [FIFO_DEPTH];
  logic           do_push;
  logic           do_pop;

  assign full  = (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]) && (wptr_q[PTR_W] != rptr_q[PTR_W]);
  assign empty = (wptr_q == rptr_q);
  assign rdata = mem_q[rptr_q[PTR_W-1:0]];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is only read while non-empty, so it carries no reset.
  always_ff @(posedge forever_cpuclk) begin
    if (do_push) mem_q[wptr_q[PTR_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/aq_rtu_fflags_collect.sv
// Buffers FP completion flags until retire, then strobes them into the CP0 fflags CSR.
module aq_rtu_fflags_collect
  import aq_rtu_fflags_collect_pkg::*;
(
  input  logic                forever_cpuclk,
  input  logic                cpurst,
  input  logic                vfpu_rtu_ex_vld,
  input  logic [FFLAGS_W-1:0] vfpu_rtu_ex_fflags,
  output logic                rtu_vfpu_ex_rdy,
  input  logic                rtu_retire_fp_vld,
  input  logic                rtu_yy_xx_flush,
  input  logic                cp0_rtu_fflags_wr,
  output logic                rtu_cp0_fflags_updt,
  output logic [FFLAGS_W-1:0] rtu_cp0_fflags,
  output logic                rtu_cp0_fs_dirty,
  output logic                rtu_retire_err
);

  logic    fifo_full;
  logic    fifo_empty;
  fflags_t head_flags;
  logic    push;
  logic    pop;

  logic    acc_vld_q, acc_vld_d;
  fflags_t acc_flags_q, acc_flags_d;
  logic    retire_err_q, retire_err_d;

  assign rtu_vfpu_ex_rdy = !fifo_full;
  assign push            = vfpu_rtu_ex_vld && !fifo_full;
  assign pop             = rtu_retire_fp_vld && !fifo_empty;

  aq_rtu_fflags_fifo u_fifo (
    .forever_cpuclk (forever_cpuclk),
    .cpurst         (cpurst),
    .push           (push),
    .pop            (pop),
    .flush          (rtu_yy_xx_flush),
    .wdata          (vfpu_rtu_ex_fflags),
    .rdata          (head_flags),
    .full           (fifo_full),
    .empty          (fifo_empty)
  );

  // A CSR write supersedes anything retiring in the same cycle.
  always_comb begin
    acc_vld_d    = 1'b0;
    acc_flags_d  = acc_flags_q;
    retire_err_d = retire_err_q | (rtu_retire_fp_vld & fifo_empty);
    if (cp0_rtu_fflags_wr) begin
      acc_flags_d = '0;
    end else if (pop) begin
      acc_vld_d   = 1'b1;
      acc_flags_d = acc_vld_q ? head_flags : (acc_flags_q | head_flags);
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      acc_vld_q    <= 1'b0;
      acc_flags_q  <= '0;
      retire_err_q <= 1'b0;
    end else begin
      acc_vld_q    <= acc_vld_d;
      acc_flags_q  <= acc_flags_d;
      retire_err_q <= retire_err_d;
    end
  end

  assign rtu_cp0_fflags_updt = acc_vld_q;
  assign rtu_cp0_fflags      = acc_flags_q;
  assign rtu_cp0_fs_dirty    = acc_vld_q && (acc_flags_q != '0);
  assign rtu_retire_err      = retire_err_q;

endmodule

// File: tb/tb_aq_rtu_fflags_collect.sv
// Scoreboard bench: driver runs a queue-based reference model, monitor checks every update strobe.
module tb_aq_rtu_fflags_collect;

  logic       forever_cpuclk = 1'b0;
  logic       cpurst = 1'b1;
  logic       vfpu_rtu_ex_vld = 1'b0;
  logic [4:0] vfpu_rtu_ex_fflags = 5'd0;
  logic       rtu_vfpu_ex_rdy;
  logic       rtu_retire_fp_vld = 1'b0;
  logic       rtu_yy_xx_flush = 1'b0;
  logic       cp0_rtu_fflags_wr = 1'b0;
  logic       rtu_cp0_fflags_updt;
  logic [4:0] rtu_cp0_fflags;
  logic       rtu_cp0_fs_dirty;
  logic       rtu_retire_err;

  aq_rtu_fflags_collect dut (
    .forever_cpuclk      (forever_cpuclk),
    .cpurst              (cpurst),
    .vfpu_rtu_ex_vld     (vfpu_rtu_ex_vld),
    .vfpu_rtu_ex_fflags  (vfpu_rtu_ex_fflags),
    .rtu_vfpu_ex_rdy     (rtu_vfpu_ex_rdy),
    .rtu_retire_fp_vld   (rtu_retire_fp_vld),
    .rtu_yy_xx_flush     (rtu_yy_xx_flush),
    .cp0_rtu_fflags_wr   (cp0_rtu_fflags_wr),
    .rtu_cp0_fflags_updt (rtu_cp0_fflags_updt),
    .rtu_cp0_fflags      (rtu_cp0_fflags),
    .rtu_cp0_fs_dirty    (rtu_cp0_fs_dirty),
    .rtu_retire_err      (rtu_retire_err)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge forever_cpuclk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [4:0] flags;
  } exp_t;
  exp_t expq[$];

  // Reference model: buffered completions, flags pending for CP0, strobe state, sticky error.
  logic [4:0] mfifo[$];
  logic [4:0] mres = 5'd0;
  bit         mvld = 1'b0;
  bit         merr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit v, input logic [4:0] f, input bit r, input bit w, input bit fl);
    bit         rdy_m;
    bit         pop;
    logic [4:0] head;
    exp_t       e;
    @(negedge forever_cpuclk);
    rdy_m = (mfifo.size() < 4);
    chk("rdy", rtu_vfpu_ex_rdy, rdy_m);
    chk("retire_err", rtu_retire_err, merr);
    vfpu_rtu_ex_vld    = v;
    vfpu_rtu_ex_fflags = f;
    rtu_retire_fp_vld  = r;
    cp0_rtu_fflags_wr  = w;
    rtu_yy_xx_flush    = fl;
    pop  = r && (mfifo.size() != 0);
    head = pop ? mfifo[0] : 5'd0;
    if (r && mfifo.size() == 0) merr = 1'b1;
    if (w) begin
      mres = 5'd0;
      mvld = 1'b0;
    end else if (pop) begin
      // A strobe in flight already delivered the older flags; otherwise they still pend.
      mres = mvld ? head : (mres | head);
      mvld = 1'b1;
      e.due   = cyc + 1;
      e.flags = mres;
      expq.push_back(e);
    end else begin
      mvld = 1'b0;
    end
    if (pop) void'(mfifo.pop_front());
    if (fl) mfifo.delete();
    else if (v && rdy_m) mfifo.push_back(f);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rdy", rtu_vfpu_ex_rdy, 1);
    chk("rst_updt", rtu_cp0_fflags_updt, 0);
    chk("rst_fflags", rtu_cp0_fflags, 0);
    chk("rst_fs_dirty", rtu_cp0_fs_dirty, 0);
    chk("rst_retire_err", rtu_retire_err, 0);
  endtask

  task automatic do_reset();
    @(posedge forever_cpuclk);
    #3;
    vfpu_rtu_ex_vld   = 1'b0;
    rtu_retire_fp_vld = 1'b0;
    cp0_rtu_fflags_wr = 1'b0;
    rtu_yy_xx_flush   = 1'b0;
    cpurst = 1'b1;
    expq.delete();
    mfifo.delete();
    mres = 5'd0;
    mvld = 1'b0;
    merr = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge forever_cpuclk);
    #3;
    cpurst = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest expectation, and none may be late or extra.
  initial begin
    exp_t e;
    forever begin
      @(negedge forever_cpuclk);
      if (rtu_cp0_fflags_updt) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_updt: got fflags %0h, expected no strobe (cycle %0d)",
                   rtu_cp0_fflags, cyc);
        end else begin
          e = expq.pop_front();
          chk("updt_cycle", cyc, e.due);
          chk("fflags", rtu_cp0_fflags, e.flags);
          chk("fs_dirty", rtu_cp0_fs_dirty, (e.flags != 5'd0));
        end
      end else begin
        chk("fs_dirty_idle", rtu_cp0_fs_dirty, 0);
        if (expq.size() != 0 && expq[0].due <= cyc) begin
          e = expq.pop_front();
          tests++;
          fails++;
          $display("FAIL missing_updt: got no strobe, expected fflags %0h (cycle %0d)",
                   e.flags, cyc);
        end
      end
    end
  end

  initial begin
    #2;
    chk_reset_outputs();
    @(posedge forever_cpuclk);
    #3;
    cpurst = 1'b0;

    // Single flow.
    drive(1, 5'b00001, 0, 0, 0);
    idle(1);
    drive(0, 5'd0, 1, 0, 0);
    idle(3);

    // Fill, stall a fifth completion, then free a slot.
    for (int i = 0; i < 4; i++) drive(1, 5'(i + 3), 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 5'b10101, 0, 0, 0);
    drive(1, 5'b10101, 1, 0, 0);
    drive(1, 5'b10101, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 5'd0, 1, 0, 0);
    idle(2);

    // Back-to-back retires.
    drive(1, 5'b10000, 0, 0, 0);
    drive(1, 5'b00100, 0, 0, 0);
    drive(0, 5'd0, 1, 0, 0);
    drive(0, 5'd0, 1, 0, 0);
    idle(2);

    // Flush with a simultaneous retire.
    drive(1, 5'b00010, 0, 0, 0);
    drive(1, 5'b01000, 0, 0, 0);
    drive(1, 5'b00001, 0, 0, 0);
    drive(1, 5'b11111, 1, 0, 1);
    idle(2);

    // CSR write collides with a retire; then zero-flag entry still strobes.
    drive(1, 5'b01000, 0, 0, 0);
    drive(1, 5'b00000, 0, 0, 0);
    drive(0, 5'd0, 1, 1, 0);
    drive(0, 5'd0, 1, 0, 0);
    idle(2);

    // Retire with nothing buffered sets the sticky error.
    drive(0, 5'd0, 1, 0, 0);
    idle(2);

    // Reset mid-stream with a strobe about to appear.
    drive(1, 5'b00110, 0, 0, 0);
    drive(1, 5'b00011, 1, 0, 0);
    do_reset();
    idle(2);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        drive(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)),
              ($urandom_range(0, 9) < 4), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 23) == 0));
      end
    end

    idle(6);
    chk("scoreboard_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
